// File: rtl/jp_pad.sv
// Purpose : NES joypad emulation (4021-style PISO) driven by host jp_latch/jp_clk strobes.
// Latency : 3 clk from a jp_latch/jp_clk pin edge to jp_data; btn_state lags btn by DB_TICKS..2*DB_TICKS.
// Backpr. : none; the host paces the shift, and strobe levels shorter than 4 clk may be missed.
//
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   btn       - raw buttons, active-high: [0]A [1]B [2]Sel [3]Start [4]Up [5]Down [6]Left [7]Right
//   jp_latch  - host latch strobe (asynchronous)
//   jp_clk    - host shift clock (asynchronous)
//   jp_data   - serial data to host, active-low (0 = pressed)
//   btn_state - debounced button state, active-high
//   bit_cnt   - bits shifted since the last latch, saturating at 8
module jp_pad #(
    parameter int              DB_W     = 16,
    parameter logic [DB_W-1:0] DB_TICKS = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] btn,
    input  logic       jp_latch,
    input  logic       jp_clk,
    output logic       jp_data,
    output logic [7:0] btn_state,
    output logic [3:0] bit_cnt
);

    localparam logic [DB_W-1:0] TICK_LAST = DB_TICKS - {{(DB_W-1){1'b0}}, 1'b1};

    // Two-FF synchronizers; jp_clk gets a third stage for rising-edge detection.
    logic [7:0] btn_s1_q, btn_s2_q;
    logic       lat_s1_q, lat_s2_q;
    logic       jck_s1_q, jck_s2_q, jck_s3_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1_q <= 8'h00;
            btn_s2_q <= 8'h00;
            lat_s1_q <= 1'b0;
            lat_s2_q <= 1'b0;
            jck_s1_q <= 1'b0;
            jck_s2_q <= 1'b0;
            jck_s3_q <= 1'b0;
        end else begin
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
            lat_s1_q <= jp_latch;
            lat_s2_q <= lat_s1_q;
            jck_s1_q <= jp_clk;
            jck_s2_q <= jck_s1_q;
            jck_s3_q <= jck_s2_q;
        end
    end

    logic clk_rise;
    assign clk_rise = jck_s2_q & ~jck_s3_q;

    // Debounce: a bit only changes when two consecutive samples agree.
    logic [DB_W-1:0] pre_q, pre_d;
    logic            tick;
    logic [7:0]      samp_q, samp_d;
    logic [7:0]      state_q, state_d;
    logic [7:0]      agree;

    assign tick  = (pre_q == TICK_LAST);
    assign agree = ~(samp_q ^ btn_s2_q);

    always_comb begin
        pre_d   = tick ? '0 : pre_q + {{(DB_W-1){1'b0}}, 1'b1};
        samp_d  = samp_q;
        state_d = state_q;
        if (tick) begin
            samp_d  = btn_s2_q;
            state_d = (state_q & ~agree) | (samp_q & agree);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q   <= '0;
            samp_q  <= 8'h00;
            state_q <= 8'h00;
        end else begin
            pre_q   <= pre_d;
            samp_q  <= samp_d;
            state_q <= state_d;
        end
    end

    // Shift register. Latch is transparent and overrides any clk_rise.
    logic [7:0] sr_q, sr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       data_q, data_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (lat_s2_q) begin
            sr_d  = state_q;
            cnt_d = 4'd0;
        end else if (clk_rise) begin
            sr_d  = {1'b0, sr_q[7:1]};
            cnt_d = (cnt_q == 4'd8) ? 4'd8 : cnt_q + 4'd1;
        end
        // Registering the next sr value keeps pin-to-output latency at 3 cycles.
        data_d = ~sr_d[0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q   <= 8'h00;
            cnt_q  <= 4'd0;
            data_q <= 1'b1;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign jp_data   = data_q;
    assign btn_state = state_q;
    assign bit_cnt   = cnt_q;

endmodule
